sysid_regs: RTL and testbench

Parametrised system-identification register block on the Avalon-MM control bus. It returns a build ID and a build timestamp, and adds a free-running 64-bit uptime counter with coherent two-word reads, a control/status register pair, and N software scratch registers. It sits on the Qsys/Avalon interconnect as a slave. Software uses it to confirm the loaded image, measure elapsed cycles and probe bus liveness.

---
 rtl/sysid_pkg.sv | 30 +++
 rtl/sysid_regs_if.sv | 25 ++
 rtl/sysid_uptime_counter.sv | 26 ++
 rtl/sysid_regs.sv | 103 ++++++++++
 tb/tb_sysid_regs.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/sysid_pkg.sv
// Shared register-map constants and helpers for the system-identification register block.
package sysid_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned CNT_W  = 64;

  localparam int unsigned SYSID        = 0;
  localparam int unsigned TIMESTAMP    = 1;
  localparam int unsigned UPTIME_LO    = 2;
  localparam int unsigned UPTIME_HI    = 3;
  localparam int unsigned CONTROL      = 4;
  localparam int unsigned STATUS       = 5;
  localparam int unsigned SCRATCH_BASE = 6;

  localparam int unsigned CTRL_COUNT_EN = 0;
  localparam int unsigned CTRL_CLEAR    = 1;
  localparam int unsigned STAT_WRAPPED  = 0;

  // Expand byte-lane enables into a per-bit write mask.
  function automatic logic [DATA_W-1:0] byte_mask(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < int'(BE_W); i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/sysid_regs_if.sv
// Avalon-MM slave bus bundle with fixed one-cycle read latency.
interface sysid_regs_if #(
  parameter int unsigned ADDR_W = 4
);
  import sysid_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );

endinterface

// File: rtl/sysid_uptime_counter.sv
// Free-running 64-bit cycle counter with enable, priority clear and a wrap indication.
module sysid_uptime_counter
  import sysid_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             wrap_c
);

  // Rolling from all-ones to zero this cycle; a clear pre-empts the increment.
  assign wrap_c = en && !clear && (&count);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sysid_regs.sv
// System-ID register block: build ID/timestamp, coherent 64-bit uptime, control/status, scratch.
module sysid_regs
  import sysid_pkg::*;
#(
  parameter logic [31:0] ID        = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP_VAL = 32'd1417958911,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned N_SCRATCH = 2
) (
  input  logic         clock,
  input  logic         reset,
  sysid_regs_if.slave  bus
);

  generate
    if ((SCRATCH_BASE + N_SCRATCH) > (1 << ADDR_W) || N_SCRATCH < 1 || N_SCRATCH > 8) begin : g_bad_cfg
      $error("sysid_regs: N_SCRATCH out of range or does not fit in ADDR_W");
    end
  endgenerate

  logic [CNT_W-1:0]  count;
  logic              wrap_c;
  logic [31:0]       shadow_hi;
  logic              count_en;
  logic              wrapped;
  logic [DATA_W-1:0] scratch [N_SCRATCH];
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  logic [31:0]       addr32;
  logic [DATA_W-1:0] wmask;
  logic              wr_ctrl;
  logic              clear_c;
  logic              w1c_c;
  logic [DATA_W-1:0] rdata_c;

  assign addr32  = 32'(bus.address);
  assign wmask   = byte_mask(bus.byteenable);
  assign wr_ctrl = bus.write && (addr32 == CONTROL) && bus.byteenable[0];
  assign clear_c = wr_ctrl && bus.writedata[CTRL_CLEAR];
  assign w1c_c   = bus.write && (addr32 == STATUS) && bus.byteenable[0]
                   && bus.writedata[STAT_WRAPPED];

  sysid_uptime_counter u_cnt (
    .clock  (clock),
    .reset  (reset),
    .en     (count_en),
    .clear  (clear_c),
    .count  (count),
    .wrap_c (wrap_c)
  );

  // Read mux reflects pre-write state; unmapped words read zero.
  always_comb begin
    rdata_c = '0;
    case (addr32)
      SYSID:     rdata_c = ID;
      TIMESTAMP: rdata_c = TIMESTAMP_VAL;
      UPTIME_LO: rdata_c = count[31:0];
      UPTIME_HI: rdata_c = shadow_hi;
      CONTROL:   rdata_c[CTRL_COUNT_EN] = count_en;
      STATUS:    rdata_c[STAT_WRAPPED]  = wrapped;
      default: begin
        for (int i = 0; i < int'(N_SCRATCH); i++) begin
          if (addr32 == SCRATCH_BASE + 32'(i)) rdata_c = scratch[i];
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdata     <= '0;
      rvalid    <= 1'b0;
      shadow_hi <= '0;
      count_en  <= 1'b1;
      wrapped   <= 1'b0;
      for (int i = 0; i < int'(N_SCRATCH); i++) scratch[i] <= '0;
    end else begin
      rvalid <= bus.read;
      if (bus.read) begin
        rdata <= rdata_c;
        // Latch the high half of the same sample so LO then HI is coherent.
        if (addr32 == UPTIME_LO) shadow_hi <= count[63:32];
      end
      if (wr_ctrl) count_en <= bus.writedata[CTRL_COUNT_EN];
      if (wrap_c) begin
        wrapped <= 1'b1;
      end else if (w1c_c) begin
        wrapped <= 1'b0;
      end
      for (int i = 0; i < int'(N_SCRATCH); i++) begin
        if (bus.write && addr32 == SCRATCH_BASE + 32'(i)) begin
          scratch[i] <= (scratch[i] & ~wmask) | (bus.writedata & wmask);
        end
      end
    end
  end

  assign bus.readdata      = rdata;
  assign bus.readdatavalid = rvalid;

endmodule

// File: tb/tb_sysid_regs.sv
// Directed self-checking bench for sysid_regs.
module tb_sysid_regs;
  import sysid_pkg::*;

  localparam logic [31:0] TB_ID = 32'h1234_5678;
  localparam logic [31:0] TB_TS = 32'd1417958911;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  sysid_regs_if #(.ADDR_W(4)) bus ();

  sysid_regs #(
    .ID            (TB_ID),
    .TIMESTAMP_VAL (TB_TS),
    .ADDR_W        (4),
    .N_SCRATCH     (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Tasks are entered just after a falling edge and return on a falling edge.
  task automatic do_read(input logic [3:0] a, output logic [31:0] d);
    bus.address = a;
    bus.read    = 1'b1;
    @(negedge clock);
    bus.read = 1'b0;
    check("rd_valid", 64'(bus.readdatavalid), 64'd1);
    d = bus.readdata;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] be);
    bus.address    = a;
    bus.writedata  = wd;
    bus.byteenable = be;
    bus.write      = 1'b1;
    @(negedge clock);
    bus.write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d, a, b;
    bus.address = '0; bus.read = 1'b0; bus.write = 1'b0;
    bus.writedata = '0; bus.byteenable = '0;
    repeat (3) @(negedge clock);
    check("rst_valid", 64'(bus.readdatavalid), 64'd0);
    check("rst_data", 64'(bus.readdata), 64'd0);
    reset = 1'b0;

    do_read(4'd0, d); check("sysid", 64'(d), 64'(TB_ID));
    do_read(4'd1, d); check("timestamp", 64'(d), 64'(TB_TS));
    do_read(4'd2, d); check("uptime_small", 64'(d < 32'd64), 64'd1);
    do_read(4'd3, d); check("uptime_hi_rst", 64'(d), 64'd0);
    do_read(4'd4, d); check("control_rst", 64'(d), 64'd1);
    do_read(4'd5, d); check("status_rst", 64'(d), 64'd0);

    // back-to-back reads keep valid high
    bus.address = 4'd0; bus.read = 1'b1;
    @(negedge clock);
    check("b2b_v0", 64'(bus.readdatavalid), 64'd1);
    check("b2b_d0", 64'(bus.readdata), 64'(TB_ID));
    bus.address = 4'd1;
    @(negedge clock);
    bus.read = 1'b0;
    check("b2b_v1", 64'(bus.readdatavalid), 64'd1);
    check("b2b_d1", 64'(bus.readdata), 64'(TB_TS));
    @(negedge clock);
    check("b2b_idle", 64'(bus.readdatavalid), 64'd0);
    check("hold_data", 64'(bus.readdata), 64'(TB_TS));

    // coherent LO/HI across the 2^32 carry
    force dut.u_cnt.count = 64'h0000_0000_FFFF_FFFE;
    bus.address = 4'd2; bus.read = 1'b1;
    @(negedge clock);
    bus.read = 1'b0;
    check("coh_lo", 64'(bus.readdata), 64'h0000_0000_FFFF_FFFE);
    force dut.u_cnt.count = 64'h0000_0000_FFFF_FFFF;
    release dut.u_cnt.count;
    repeat (4) @(negedge clock);
    do_read(4'd3, d); check("coh_hi", 64'(d), 64'd0);

    // scratch byte enables, unmapped and RO writes
    do_write(4'd6, 32'hDEAD_BEEF, 4'b0101);
    do_read(4'd6, d); check("scr0_be", 64'(d), 64'h00AD_00EF);
    do_read(4'd7, d); check("scr1_zero", 64'(d), 64'd0);
    do_write(4'd6, 32'h1122_3344, 4'b1000);
    do_read(4'd6, d); check("scr0_merge", 64'(d), 64'h11AD_00EF);
    do_write(4'd15, 32'hFFFF_FFFF, 4'hF);
    do_read(4'd15, d); check("unmapped", 64'(d), 64'd0);
    do_write(4'd0, 32'hFFFF_FFFF, 4'hF);
    do_read(4'd0, d); check("ro_ignored", 64'(d), 64'(TB_ID));

    // read and write in the same cycle return the old value
    bus.address = 4'd7; bus.writedata = 32'hA5A5_A5A5; bus.byteenable = 4'hF;
    bus.read = 1'b1; bus.write = 1'b1;
    @(negedge clock);
    bus.read = 1'b0; bus.write = 1'b0;
    check("rw_old", 64'(bus.readdata), 64'd0);
    do_read(4'd7, d); check("rw_new", 64'(d), 64'hA5A5_A5A5);

    // count enable and clear
    do_write(4'd4, 32'h0, 4'hF);
    do_read(4'd4, d); check("ctrl_off", 64'(d), 64'd0);
    repeat (10) @(negedge clock);
    do_read(4'd2, a);
    do_read(4'd2, b); check("held", 64'(a == b), 64'd1);
    do_write(4'd4, 32'h3, 4'hF);
    do_read(4'd2, a); check("cleared", 64'(a <= 32'd2), 64'd1);
    do_read(4'd2, b); check("resumed", 64'(b > a), 64'd1);
    do_read(4'd4, d); check("ctrl_on", 64'(d), 64'd1);

    // wrap sets sticky status
    force dut.u_cnt.count = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clock);
    force dut.u_cnt.count = 64'd5;
    release dut.u_cnt.count;
    do_read(4'd5, d); check("wrapped", 64'(d), 64'd1);
    do_write(4'd5, 32'h1, 4'b1110);
    do_read(4'd5, d); check("w1c_lane_off", 64'(d), 64'd1);
    // W1C coincident with a wrap: set wins
    force dut.u_cnt.count = 64'hFFFF_FFFF_FFFF_FFFF;
    do_write(4'd5, 32'h1, 4'b0001);
    force dut.u_cnt.count = 64'd5;
    release dut.u_cnt.count;
    do_read(4'd5, d); check("set_wins", 64'(d), 64'd1);
    do_write(4'd5, 32'h1, 4'b0001);
    do_read(4'd5, d); check("w1c", 64'(d), 64'd0);

    // reset drops a pending read
    do_write(4'd4, 32'h0, 4'hF);
    bus.address = 4'd6; bus.read = 1'b1; reset = 1'b1;
    @(negedge clock);
    bus.read = 1'b0;
    check("rst_no_pulse", 64'(bus.readdatavalid), 64'd0);
    check("rst_rdata", 64'(bus.readdata), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    check("rst_idle", 64'(bus.readdatavalid), 64'd0);
    do_read(4'd6, d); check("rst_scr0", 64'(d), 64'd0);
    do_read(4'd4, d); check("rst_ctrl", 64'(d), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
